load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits downstream of the EX/MEM pipeline register, between the MEM stage and word-organised data memory.
- Converts one EX/MEM memory request (address, store data, read_write_sel) into one or two 32-bit word transactions on a req/ack bus:
  - generates byte enables;
  - splits misaligned half/word accesses across two words;
  - assembles and sign/zero-extends load data.
- Drives busy so the pipeline holds EX/MEM and MEM/WB until the access completes.

Parameters:
- SPLIT_MISALIGNED, 1: 1 = split misaligned accesses into two word transactions; 0 = flag them and skip the memory access.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- address_i  in  32  byte address (ALU result from EX/MEM)
- write_data_i  in  32  store data (forwarded rs2 from EX/MEM)
- read_write_sel_i  in  4  op code, see Behaviour
- hold_i  in  1  another unit is stalling the pipeline (instruction-side busy)
- read_data_o  out  32  extended load result, valid in DONE
- busy_o  out  1  stall request to the pipeline
- misaligned_o  out  1  pulses in DONE when the completed op was misaligned
- mem_req_o  out  1  word request, held high until ack
- mem_we_o  out  1  1 = write
- mem_addr_o  out  30  word address [31:2]
- mem_wdata_o  out  32  lane-positioned write data
- mem_be_o  out  4  byte enables; also asserted for reads
- mem_rdata_i  in  32  read word, valid with ack
- mem_ack_i  in  1  completes the current request; memory latency is 1..N cycles

Behaviour:
- Op encoding, sel[3:2]:
  - 00 = none
  - 01 = store
  - 10 = load signed
  - 11 = load unsigned
- Size encoding, sel[1:0]:
  - 00 = byte
  - 01 = half
  - 10 = word
  - 11 = reserved, treated as none
- Reset: state=IDLE. read_data_o, mem_addr_o, mem_wdata_o = 0; mem_be_o = 0; busy_o, mem_req_o, mem_we_o, misaligned_o = 0.
- Reset asserted mid-transaction aborts immediately: mem_req_o drops asynchronously and partial load data is discarded.
- Misaligned means:
  - half with addr[1:0]==3;
  - word with addr[1:0]!=0.
  - Bytes are never misaligned.
- State machine:
  - IDLE:
    - busy_o = (op != none), combinational.
    - On a valid op, capture address, data, op and offset, then go to ACC0.
    - If misaligned and SPLIT_MISALIGNED=0, go straight to DONE with misaligned flag set, no memory access, read_data_o=0.
  - ACC0:
    - mem_req_o=1; mem_addr_o = addr[31:2]; mem_be_o = size mask << offset, truncated to 4 lanes; mem_wdata_o = data << (8*offset).
    - Outputs stay stable until mem_ack_i.
    - On ack: if split, capture mem_rdata_i into the low buffer and go to ACC1; otherwise go to DONE.
  - ACC1:
    - mem_addr_o = addr[31:2]+1, wrapping 0x3FFFFFFF -> 0.
    - mem_be_o = remaining low lanes; mem_wdata_o = data >> (8*(4-offset)).
    - On ack, go to DONE.
  - DONE:
    - busy_o=0.
    - read_data_o = registered assembled load value, byte/half extended per sel[2]; 0 for stores.
    - misaligned_o reflects the op.
    - If hold_i=1, stay in DONE so the same EX/MEM entry is not reissued; otherwise go to IDLE.
- busy_o=1 in ACC0 and ACC1.
- Minimum latency for an aligned access with 1-cycle ack: busy in IDLE, ACC0 (2 cycles); data in DONE (3rd cycle).
- A split access adds one ACC1 phase.
- mem_ack_i outside ACC0/ACC1 is ignored.
- Inputs are not sampled after capture; changes during ACC*/DONE have no effect.
- mem_we_o = (op==store) in ACC0 and ACC1, 0 otherwise.

Decomposition:
- Package lsu_pkg holds:
  - op and size encodings (LSU_NONE, LSU_STORE, LSU_LOAD_S, LSU_LOAD_U, SZ_B, SZ_H, SZ_W);
  - state encoding (IDLE, ACC0, ACC1, DONE);
  - the misalignment function.
- Sub-module lsu_align is combinational. It handles byte-enable generation, store lane shifting, and assembly plus sign/zero extension of one or two read words.
- The FSM and registers live in load_store_unit.

Test Plan:
- Aligned SW, addr=0x100, data=0xDEADBEEF, ack after 3 cycles -> one request; mem_addr=0x40, be=1111, we=1, wdata=0xDEADBEEF; busy 1 for 4 cycles, then DONE.
- LB signed, addr=0x203, mem word=0x80FFFFFF -> be=1000; read_data_o=0xFFFFFF80. The same access as LBU -> 0x00000080.
- Misaligned LW, addr=0x102, words 0x11223344 @0x40 and 0x55667788 @0x41, SPLIT=1:
  - two requests, be=1100 then 0011;
  - read_data_o=0x77881122; misaligned_o=1.
- Misaligned SH, addr=0x0FFFFFFF… use addr=0xFFFFFFFF, data=0xABCD:
  - first request word 0x3FFFFFFF be=1000 wdata byte3=0xCD;
  - second request word 0x0 be=0001 wdata byte0=0xAB.
- DONE with hold_i=1 for 5 cycles, same sel held -> no new mem_req_o, busy_o=0, read_data_o stable. The next op issues only after hold_i drops.
- rst_i asserted in ACC0 before ack -> mem_req_o=0 and busy_o=0 immediately, state IDLE. After release with sel=none, no request is issued.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: operation, access size, FSM state,
// and the misalignment rule used when a request is captured.
package lsu_pkg;

  typedef enum logic [1:0] {
    LSU_NONE   = 2'b00,
    LSU_STORE  = 2'b01,
    LSU_LOAD_S = 2'b10,
    LSU_LOAD_U = 2'b11
  } lsu_op_e;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_RSV = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACC0 = 2'b01,
    ACC1 = 2'b10,
    DONE = 2'b11
  } lsu_state_e;

  // Bytes never straddle a word; halves only do so at offset 3.
  function automatic logic lsu_misaligned(input lsu_size_e size, input logic [1:0] offset);
    case (size)
      SZ_H:    return (offset == 2'd3);
      SZ_W:    return (offset != 2'd0);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the load/store unit: byte enables and store data for both
// word phases, plus assembly and extension of load data from one or two words.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        load_signed,
  input  logic [31:0] store_data,
  input  logic [31:0] word0,
  input  logic [31:0] word1,
  output logic [3:0]  be0,
  output logic [3:0]  be1,
  output logic [31:0] wdata0,
  output logic [31:0] wdata1,
  output logic [31:0] load_data
);

  lsu_size_e   sz;
  logic [3:0]  mask;
  logic [7:0]  be_wide;
  logic [63:0] wdata_wide;
  logic [63:0] rd_wide;

  assign sz = lsu_size_e'(size);

  always_comb begin
    case (sz)
      SZ_B:    mask = 4'b0001;
      SZ_H:    mask = 4'b0011;
      SZ_W:    mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
  end

  // The upper half of each 64-bit view is what spills into the next word.
  assign be_wide    = {4'b0000, mask} << offset;
  assign wdata_wide = {32'd0, store_data} << {offset, 3'b000};
  assign rd_wide    = {word1, word0} >> {offset, 3'b000};

  assign be0    = be_wide[3:0];
  assign be1    = be_wide[7:4];
  assign wdata0 = wdata_wide[31:0];
  assign wdata1 = wdata_wide[63:32];

  always_comb begin
    case (sz)
      SZ_B:    load_data = {{24{load_signed & rd_wide[7]}}, rd_wide[7:0]};
      SZ_H:    load_data = {{16{load_signed & rd_wide[15]}}, rd_wide[15:0]};
      SZ_W:    load_data = rd_wide[31:0];
      default: load_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: turns one EX/MEM request into one or two word
// transactions on a req/ack bus and stalls the pipeline until it completes.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned SPLIT_MISALIGNED = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] address_i,
  input  logic [31:0] write_data_i,
  input  logic [3:0]  read_write_sel_i,
  input  logic        hold_i,
  output logic [31:0] read_data_o,
  output logic        busy_o,
  output logic        misaligned_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [29:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i
);

  lsu_state_e  state_reg, state_next;
  logic [29:0] addr_reg, addr_next;
  logic [1:0]  offset_reg, offset_next;
  logic [31:0] data_reg, data_next;
  lsu_op_e     op_reg, op_next;
  lsu_size_e   size_reg, size_next;
  logic        mis_reg, mis_next;
  logic [31:0] low_buf_reg, low_buf_next;
  logic [31:0] read_data_reg, read_data_next;

  lsu_op_e     sel_op;
  lsu_size_e   sel_size;
  logic        sel_valid;
  logic        sel_mis;

  logic [3:0]  be0, be1;
  logic [31:0] wdata0, wdata1, load_data, word0, result;
  logic        is_store;

  assign sel_op    = lsu_op_e'(read_write_sel_i[3:2]);
  assign sel_size  = lsu_size_e'(read_write_sel_i[1:0]);
  assign sel_valid = (sel_op != LSU_NONE) && (sel_size != SZ_RSV);
  assign sel_mis   = lsu_misaligned(sel_size, address_i[1:0]);

  // During the second phase the first word comes from the low buffer.
  assign word0    = (state_reg == ACC1) ? low_buf_reg : mem_rdata_i;
  assign is_store = (op_reg == LSU_STORE);
  assign result   = is_store ? 32'd0 : load_data;

  lsu_align u_align (
    .size        (size_reg),
    .offset      (offset_reg),
    .load_signed (op_reg == LSU_LOAD_S),
    .store_data  (data_reg),
    .word0       (word0),
    .word1       (mem_rdata_i),
    .be0         (be0),
    .be1         (be1),
    .wdata0      (wdata0),
    .wdata1      (wdata1),
    .load_data   (load_data)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      offset_reg    <= '0;
      data_reg      <= '0;
      op_reg        <= LSU_NONE;
      size_reg      <= SZ_B;
      mis_reg       <= 1'b0;
      low_buf_reg   <= '0;
      read_data_reg <= '0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      offset_reg    <= offset_next;
      data_reg      <= data_next;
      op_reg        <= op_next;
      size_reg      <= size_next;
      mis_reg       <= mis_next;
      low_buf_reg   <= low_buf_next;
      read_data_reg <= read_data_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    offset_next    = offset_reg;
    data_next      = data_reg;
    op_next        = op_reg;
    size_next      = size_reg;
    mis_next       = mis_reg;
    low_buf_next   = low_buf_reg;
    read_data_next = read_data_reg;
    busy_o         = 1'b0;
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_addr_o     = '0;
    mem_be_o       = '0;
    mem_wdata_o    = '0;

    case (state_reg)
      IDLE: begin
        busy_o = sel_valid;
        if (sel_valid) begin
          addr_next   = address_i[31:2];
          offset_next = address_i[1:0];
          data_next   = write_data_i;
          op_next     = sel_op;
          size_next   = sel_size;
          mis_next    = sel_mis;
          if (sel_mis && (SPLIT_MISALIGNED == 0)) begin
            read_data_next = 32'd0;
            state_next     = DONE;
          end else begin
            state_next = ACC0;
          end
        end
      end
      ACC0: begin
        busy_o      = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = is_store;
        mem_addr_o  = addr_reg;
        mem_be_o    = be0;
        mem_wdata_o = wdata0;
        if (mem_ack_i) begin
          // Only split accesses reach ACC0 with the misaligned flag set.
          if (mis_reg) begin
            low_buf_next = mem_rdata_i;
            state_next   = ACC1;
          end else begin
            read_data_next = result;
            state_next     = DONE;
          end
        end
      end
      ACC1: begin
        busy_o      = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = is_store;
        mem_addr_o  = addr_reg + 30'd1;
        mem_be_o    = be1;
        mem_wdata_o = wdata1;
        if (mem_ack_i) begin
          read_data_next = result;
          state_next     = DONE;
        end
      end
      DONE: begin
        if (!hold_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign read_data_o  = read_data_reg;
  assign misaligned_o = (state_reg == DONE) && mis_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: each task drives one scenario cycle by
// cycle and checks bus and pipeline outputs against hand-computed values.
module tb_load_store_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] address_i = '0;
  logic [31:0] write_data_i = '0;
  logic [3:0]  read_write_sel_i = '0;
  logic        hold_i = 1'b0;
  logic [31:0] read_data_o;
  logic        busy_o;
  logic        misaligned_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [29:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_ack_i = 1'b0;

  int vec = 0;
  int errs = 0;

  localparam logic [3:0] SEL_NONE = 4'b0000;
  localparam logic [3:0] SEL_SW   = 4'b0110;
  localparam logic [3:0] SEL_SH   = 4'b0101;
  localparam logic [3:0] SEL_SB   = 4'b0100;
  localparam logic [3:0] SEL_LB   = 4'b1000;
  localparam logic [3:0] SEL_LBU  = 4'b1100;
  localparam logic [3:0] SEL_LW   = 4'b1010;
  localparam logic [3:0] SEL_LHU  = 4'b1101;
  localparam logic [3:0] SEL_RSV  = 4'b1011;

  load_store_unit #(.SPLIT_MISALIGNED(1)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .address_i        (address_i),
    .write_data_i     (write_data_i),
    .read_write_sel_i (read_write_sel_i),
    .hold_i           (hold_i),
    .read_data_o      (read_data_o),
    .busy_o           (busy_o),
    .misaligned_o     (misaligned_o),
    .mem_req_o        (mem_req_o),
    .mem_we_o         (mem_we_o),
    .mem_addr_o       (mem_addr_o),
    .mem_wdata_o      (mem_wdata_o),
    .mem_be_o         (mem_be_o),
    .mem_rdata_i      (mem_rdata_i),
    .mem_ack_i        (mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic cyc;
    @(negedge clk_i);
  endtask

  task automatic test_reset;
    cyc(); #1;
    vec++; if (busy_o !== 1'b0) begin errs++; $display("FAIL rst_busy: got %0b want 0", busy_o); end
    vec++; if (mem_req_o !== 1'b0) begin errs++; $display("FAIL rst_req: got %0b want 0", mem_req_o); end
    vec++; if (read_data_o !== 32'h0) begin errs++; $display("FAIL rst_rdata: got %h want 0", read_data_o); end
    vec++; if (mem_be_o !== 4'h0) begin errs++; $display("FAIL rst_be: got %b want 0000", mem_be_o); end
    vec++; if (misaligned_o !== 1'b0) begin errs++; $display("FAIL rst_mis: got %0b want 0", misaligned_o); end
    cyc(); rst_i = 1'b0;
    $display("tx reset released");
  endtask

  task automatic test_sw;
    cyc(); read_write_sel_i = SEL_SW; address_i = 32'h100; write_data_i = 32'hDEADBEEF; #1;
    vec++; if (busy_o !== 1'b1) begin errs++; $display("FAIL sw_busy_idle: got %0b want 1", busy_o); end
    vec++; if (mem_req_o !== 1'b0) begin errs++; $display("FAIL sw_req_idle: got %0b want 0", mem_req_o); end
    // inputs change after capture and must be ignored
    cyc(); read_write_sel_i = SEL_NONE; address_i = 32'h0; write_data_i = 32'h0; #1;
    vec++; if (mem_req_o !== 1'b1) begin errs++; $display("FAIL sw_req: got %0b want 1", mem_req_o); end
    vec++; if (mem_addr_o !== 30'h40) begin errs++; $display("FAIL sw_addr: got %h want 40", mem_addr_o); end
    vec++; if (mem_be_o !== 4'b1111) begin errs++; $display("FAIL sw_be: got %b want 1111", mem_be_o); end
    vec++; if (mem_we_o !== 1'b1) begin errs++; $display("FAIL sw_we: got %0b want 1", mem_we_o); end
    vec++; if (mem_wdata_o !== 32'hDEADBEEF) begin errs++; $display("FAIL sw_wdata: got %h want deadbeef", mem_wdata_o); end
    cyc(); #1;
    vec++; if (busy_o !== 1'b1 || mem_req_o !== 1'b1) begin errs++; $display("FAIL sw_wait2: got busy=%0b req=%0b want 1/1", busy_o, mem_req_o); end
    vec++; if (mem_wdata_o !== 32'hDEADBEEF) begin errs++; $display("FAIL sw_wdata_stable: got %h want deadbeef", mem_wdata_o); end
    cyc(); mem_ack_i = 1'b1; #1;
    vec++; if (busy_o !== 1'b1 || mem_req_o !== 1'b1) begin errs++; $display("FAIL sw_wait3: got busy=%0b req=%0b want 1/1", busy_o, mem_req_o); end
    cyc(); mem_ack_i = 1'b0; #1;
    vec++; if (busy_o !== 1'b0) begin errs++; $display("FAIL sw_done_busy: got %0b want 0", busy_o); end
    vec++; if (mem_req_o !== 1'b0 || mem_we_o !== 1'b0) begin errs++; $display("FAIL sw_done_req: got req=%0b we=%0b want 0/0", mem_req_o, mem_we_o); end
    vec++; if (read_data_o !== 32'h0) begin errs++; $display("FAIL sw_done_rdata: got %h want 0", read_data_o); end
    $display("tx SW addr=00000100 data=deadbeef");
  endtask

  task automatic test_sb;
    cyc(); read_write_sel_i = SEL_SB; address_i = 32'h401; write_data_i = 32'h1234565A; #1;
    cyc(); read_write_sel_i = SEL_NONE; #1;
    vec++; if (mem_be_o !== 4'b0010) begin errs++; $display("FAIL sb_be: got %b want 0010", mem_be_o); end
    vec++; if (mem_wdata_o[15:8] !== 8'h5A) begin errs++; $display("FAIL sb_lane: got %h want 5a", mem_wdata_o[15:8]); end
    vec++; if (mem_addr_o !== 30'h100) begin errs++; $display("FAIL sb_addr: got %h want 100", mem_addr_o); end
    mem_ack_i = 1'b1;
    cyc(); mem_ack_i = 1'b0; #1;
    vec++; if (misaligned_o !== 1'b0) begin errs++; $display("FAIL sb_mis: got %0b want 0", misaligned_o); end
    $display("tx SB addr=00000401 data=5a");
  endtask

  task automatic test_lb(input logic [3:0] sel, input logic [31:0] want, input string nm);
    cyc(); read_write_sel_i = sel; address_i = 32'h203; #1;
    cyc(); read_write_sel_i = SEL_NONE; #1;
    vec++; if (mem_be_o !== 4'b1000) begin errs++; $display("FAIL %s_be: got %b want 1000", nm, mem_be_o); end
    vec++; if (mem_we_o !== 1'b0) begin errs++; $display("FAIL %s_we: got %0b want 0", nm, mem_we_o); end
    mem_ack_i = 1'b1; mem_rdata_i = 32'h80FFFFFF;
    cyc(); mem_ack_i = 1'b0; mem_rdata_i = 32'h13579BDF; #1;
    vec++; if (read_data_o !== want) begin errs++; $display("FAIL %s_rdata: got %h want %h", nm, read_data_o, want); end
    $display("tx %s addr=00000203 rdata=%h", nm, read_data_o);
  endtask

  task automatic test_misaligned_lw;
    cyc(); read_write_sel_i = SEL_LW; address_i = 32'h102; #1;
    cyc(); read_write_sel_i = SEL_NONE; #1;
    vec++; if (mem_addr_o !== 30'h40 || mem_be_o !== 4'b1100) begin errs++; $display("FAIL lw0: got addr=%h be=%b want 40/1100", mem_addr_o, mem_be_o); end
    mem_ack_i = 1'b1; mem_rdata_i = 32'h11223344;
    cyc(); mem_rdata_i = 32'h55667788; #1;
    vec++; if (mem_req_o !== 1'b1 || busy_o !== 1'b1) begin errs++; $display("FAIL lw1_req: got req=%0b busy=%0b want 1/1", mem_req_o, busy_o); end
    vec++; if (mem_addr_o !== 30'h41 || mem_be_o !== 4'b0011) begin errs++; $display("FAIL lw1: got addr=%h be=%b want 41/0011", mem_addr_o, mem_be_o); end
    cyc(); mem_ack_i = 1'b0; mem_rdata_i = 32'h0; #1;
    vec++; if (read_data_o !== 32'h77881122) begin errs++; $display("FAIL lw_rdata: got %h want 77881122", read_data_o); end
    vec++; if (misaligned_o !== 1'b1) begin errs++; $display("FAIL lw_mis: got %0b want 1", misaligned_o); end
    $display("tx LW addr=00000102 rdata=%h", read_data_o);
  endtask

  task automatic test_wrap_sh;
    cyc(); read_write_sel_i = SEL_SH; address_i = 32'hFFFFFFFF; write_data_i = 32'h0000ABCD; #1;
    cyc(); read_write_sel_i = SEL_NONE; #1;
    vec++; if (mem_addr_o !== 30'h3FFFFFFF || mem_be_o !== 4'b1000) begin errs++; $display("FAIL sh0: got addr=%h be=%b want 3fffffff/1000", mem_addr_o, mem_be_o); end
    vec++; if (mem_wdata_o !== 32'hCD000000) begin errs++; $display("FAIL sh0_wdata: got %h want cd000000", mem_wdata_o); end
    mem_ack_i = 1'b1;
    cyc(); #1;
    vec++; if (mem_addr_o !== 30'h0 || mem_be_o !== 4'b0001) begin errs++; $display("FAIL sh1: got addr=%h be=%b want 0/0001", mem_addr_o, mem_be_o); end
    vec++; if (mem_wdata_o !== 32'h000000AB || mem_we_o !== 1'b1) begin errs++; $display("FAIL sh1_wdata: got %h we=%0b want 000000ab/1", mem_wdata_o, mem_we_o); end
    cyc(); mem_ack_i = 1'b0; #1;
    vec++; if (misaligned_o !== 1'b1 || read_data_o !== 32'h0) begin errs++; $display("FAIL sh_done: got mis=%0b rdata=%h want 1/0", misaligned_o, read_data_o); end
    $display("tx SH addr=ffffffff data=abcd");
  endtask

  task automatic test_hold;
    cyc(); read_write_sel_i = SEL_LHU; address_i = 32'h202; hold_i = 1'b1; #1;
    cyc(); #1;
    mem_ack_i = 1'b1; mem_rdata_i = 32'hBEEF1234;
    for (int i = 0; i < 5; i++) begin
      // a stray ack while parked must not disturb the result
      cyc(); mem_ack_i = (i == 2); mem_rdata_i = 32'h0BAD0BAD; #1;
      vec++; if (mem_req_o !== 1'b0 || busy_o !== 1'b0) begin errs++; $display("FAIL hold_%0d: got req=%0b busy=%0b want 0/0", i, mem_req_o, busy_o); end
      vec++; if (read_data_o !== 32'h0000BEEF) begin errs++; $display("FAIL hold_rdata_%0d: got %h want 0000beef", i, read_data_o); end
    end
    cyc(); mem_ack_i = 1'b0; hold_i = 1'b0; #1;
    vec++; if (mem_req_o !== 1'b0) begin errs++; $display("FAIL hold_release: got req=%0b want 0", mem_req_o); end
    cyc(); #1;
    vec++; if (busy_o !== 1'b1 || mem_req_o !== 1'b0) begin errs++; $display("FAIL hold_reidle: got busy=%0b req=%0b want 1/0", busy_o, mem_req_o); end
    cyc(); read_write_sel_i = SEL_NONE; #1;
    vec++; if (mem_req_o !== 1'b1 || mem_addr_o !== 30'h80) begin errs++; $display("FAIL hold_reissue: got req=%0b addr=%h want 1/80", mem_req_o, mem_addr_o); end
    mem_ack_i = 1'b1; mem_rdata_i = 32'hBEEF1234;
    cyc(); mem_ack_i = 1'b0; #1;
    $display("tx LHU addr=00000202 rdata=%h held", read_data_o);
  endtask

  task automatic test_reserved;
    cyc(); read_write_sel_i = SEL_RSV; address_i = 32'h300; #1;
    vec++; if (busy_o !== 1'b0) begin errs++; $display("FAIL rsv_busy: got %0b want 0", busy_o); end
    cyc(); read_write_sel_i = SEL_NONE; #1;
    vec++; if (mem_req_o !== 1'b0) begin errs++; $display("FAIL rsv_req: got %0b want 0", mem_req_o); end
    $display("tx reserved size ignored");
  endtask

  task automatic test_reset_mid;
    cyc(); read_write_sel_i = SEL_LW; address_i = 32'h300; #1;
    cyc(); read_write_sel_i = SEL_NONE; #1;
    vec++; if (mem_req_o !== 1'b1) begin errs++; $display("FAIL rmid_req: got %0b want 1", mem_req_o); end
    rst_i = 1'b1; #1;
    vec++; if (mem_req_o !== 1'b0 || busy_o !== 1'b0) begin errs++; $display("FAIL rmid_async: got req=%0b busy=%0b want 0/0", mem_req_o, busy_o); end
    vec++; if (read_data_o !== 32'h0) begin errs++; $display("FAIL rmid_rdata: got %h want 0", read_data_o); end
    cyc(); cyc(); rst_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc(); #1;
      vec++; if (mem_req_o !== 1'b0 || busy_o !== 1'b0) begin errs++; $display("FAIL rmid_after_%0d: got req=%0b busy=%0b want 0/0", i, mem_req_o, busy_o); end
    end
    $display("tx reset during ACC0");
  endtask

  initial begin
    test_reset();
    test_sw();
    test_sb();
    test_lb(SEL_LB, 32'hFFFFFF80, "LB");
    test_lb(SEL_LBU, 32'h00000080, "LBU");
    test_misaligned_lw();
    test_wrap_sh();
    test_hold();
    test_reserved();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
